axis_gather_fifo: RTL and testbench

AXIS_GATHER_FIFO -- requirements
Module: axis_gather_fifo

---
 rtl/axis_gather_fifo_pkg.sv | 9 +
 rtl/axis_gather_fifo.sv | 164 ++++++++++++++++
 tb/tb_axis_gather_fifo.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_gather_fifo_pkg.sv
// Shared helpers for the gathering FIFO.
package axis_gather_fifo_pkg;

  // Unsigned minimum, used when sizing a group.
  function automatic int unsigned min_u(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_gather_fifo.sv
// Single-sample AXI-Stream in, OUT_MUX-lane AXI-Stream out.
// Samples are packed into output beats of up to OUT_MUX lanes.
// A beat is closed early at a packet boundary, so a beat never spans two packets.
module axis_gather_fifo
  import axis_gather_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 1,
  parameter int FIFO_LEN   = 8,
  parameter int OUT_MUX    = 2
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [DATA_WIDTH-1:0]            s_axis_in_tdata,
  input  logic [USER_WIDTH-1:0]            s_axis_in_tuser,
  input  logic                             s_axis_in_tlast,
  input  logic                             s_axis_in_tvalid,
  output logic                             s_axis_in_tready,
  output logic [DATA_WIDTH*OUT_MUX-1:0]    m_axis_out_tdata,
  output logic [USER_WIDTH*OUT_MUX-1:0]    m_axis_out_tuser,
  output logic [OUT_MUX-1:0]               m_axis_out_tkeep,
  output logic                             m_axis_out_tlast,
  output logic                             m_axis_out_tvalid,
  input  logic                             m_axis_out_tready,
  output logic [$clog2(FIFO_LEN):0]        m_axis_out_tlevel,
  output logic                             m_axis_out_tempty
);

  localparam int AW = $clog2(FIFO_LEN);
  localparam int PW = AW + 1;
  localparam int NW = $clog2(OUT_MUX + 1);

  // Storage is never reset; the pointers define what is valid.
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_LEN];
  logic [USER_WIDTH-1:0] r_mem_user [FIFO_LEN];
  logic                  r_mem_last [FIFO_LEN];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_last_cnt;

  logic [DATA_WIDTH*OUT_MUX-1:0] r_out_data;
  logic [USER_WIDTH*OUT_MUX-1:0] r_out_user;
  logic [OUT_MUX-1:0]            r_out_keep;
  logic                          r_out_last;
  logic                          r_out_valid;

  logic [PW-1:0]                 w_level;
  logic                          w_wr_en;
  logic                          w_avail;
  logic                          w_load;
  logic                          w_grp_last;
  logic [NW-1:0]                 w_n;
  logic [OUT_MUX-1:0]            w_last_flags;
  logic [DATA_WIDTH*OUT_MUX-1:0] w_lane_data;
  logic [USER_WIDTH*OUT_MUX-1:0] w_lane_user;
  logic [OUT_MUX-1:0]            w_lane_keep;

  // Group length: up to and including the first stored tlast, capped at
  // OUT_MUX lanes and at the number of samples present. Flags beyond the
  // stored level are already masked off by the caller.
  function automatic logic [NW-1:0] group_len(input logic [OUT_MUX-1:0] flags,
                                              input logic [PW-1:0]      level);
    logic [NW-1:0] len;
    logic          found;
    len   = NW'(min_u(32'(level), OUT_MUX));
    found = 1'b0;
    for (int k = 0; k < OUT_MUX; k++) begin
      if (!found && flags[k]) begin
        len   = NW'(k + 1);
        found = 1'b1;
      end
    end
    return len;
  endfunction

  assign w_level          = r_wr_ptr - r_rd_ptr;
  assign s_axis_in_tready = !reset_i && (w_level != PW'(FIFO_LEN));
  assign w_wr_en          = s_axis_in_tvalid && s_axis_in_tready;

  // tlast flags of the entries that could join the next group.
  always_comb begin
    w_last_flags = '0;
    for (int k = 0; k < OUT_MUX; k++) begin
      if (PW'(k) < w_level) begin
        w_last_flags[k] = r_mem_last[AW'(r_rd_ptr + PW'(k))];
      end
    end
  end

  // A group ends on a tlast exactly when one lies in its search window.
  assign w_n        = group_len(w_last_flags, w_level);
  assign w_grp_last = |w_last_flags;
  assign w_avail    = (w_level >= PW'(OUT_MUX)) || (r_last_cnt != '0);
  assign w_load     = w_avail && (!r_out_valid || m_axis_out_tready);

  // Lane assembly for the next output beat; unused lanes are zeroed.
  always_comb begin
    w_lane_data = '0;
    w_lane_user = '0;
    w_lane_keep = '0;
    for (int k = 0; k < OUT_MUX; k++) begin
      if (NW'(k) < w_n) begin
        w_lane_data[DATA_WIDTH*k +: DATA_WIDTH] = r_mem_data[AW'(r_rd_ptr + PW'(k))];
        w_lane_user[USER_WIDTH*k +: USER_WIDTH] = r_mem_user[AW'(r_rd_ptr + PW'(k))];
        w_lane_keep[k]                          = 1'b1;
      end
    end
  end

  // Sample storage write.
  always_ff @(posedge clk_i) begin
    if (w_wr_en) begin
      r_mem_data[r_wr_ptr[AW-1:0]] <= s_axis_in_tdata;
      r_mem_user[r_wr_ptr[AW-1:0]] <= s_axis_in_tuser;
      r_mem_last[r_wr_ptr[AW-1:0]] <= s_axis_in_tlast;
    end
  end

  // Pointers and count of stored packet ends.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_last_cnt <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_load)  r_rd_ptr <= r_rd_ptr + PW'(w_n);
      case ({w_wr_en && s_axis_in_tlast, w_load && w_grp_last})
        2'b10:   r_last_cnt <= r_last_cnt + PW'(1);
        2'b01:   r_last_cnt <= r_last_cnt - PW'(1);
        default: r_last_cnt <= r_last_cnt;
      endcase
    end
  end

  // Output register: load a new group or retire the current beat.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_user  <= '0;
      r_out_keep  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_lane_data;
      r_out_user  <= w_lane_user;
      r_out_keep  <= w_lane_keep;
      r_out_last  <= w_grp_last;
    end else if (r_out_valid && m_axis_out_tready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign m_axis_out_tdata  = r_out_data;
  assign m_axis_out_tuser  = r_out_user;
  assign m_axis_out_tkeep  = r_out_keep;
  assign m_axis_out_tlast  = r_out_last;
  assign m_axis_out_tvalid = r_out_valid;
  assign m_axis_out_tlevel = w_level;
  assign m_axis_out_tempty = (w_level == '0);

endmodule

// File: tb/tb_axis_gather_fifo.sv
// Scoreboard bench for axis_gather_fifo at DATA_WIDTH=16, OUT_MUX=2, FIFO_LEN=8.
module tb_axis_gather_fifo;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  u;
    logic [1:0]  k;
    logic        l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [15:0] s_tdata;
  logic        s_tuser;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] m_tdata;
  logic [1:0]  m_tuser;
  logic [1:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [3:0]  m_tlevel;
  logic        m_tempty;

  int    n_vec = 0;
  int    n_err = 0;
  bit    rnd_mode = 1'b0;
  beat_t sb[$];

  axis_gather_fifo #(
    .DATA_WIDTH(16), .USER_WIDTH(1), .FIFO_LEN(8), .OUT_MUX(2)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .s_axis_in_tdata   (s_tdata),
    .s_axis_in_tuser   (s_tuser),
    .s_axis_in_tlast   (s_tlast),
    .s_axis_in_tvalid  (s_tvalid),
    .s_axis_in_tready  (s_tready),
    .m_axis_out_tdata  (m_tdata),
    .m_axis_out_tuser  (m_tuser),
    .m_axis_out_tkeep  (m_tkeep),
    .m_axis_out_tlast  (m_tlast),
    .m_axis_out_tvalid (m_tvalid),
    .m_axis_out_tready (m_tready),
    .m_axis_out_tlevel (m_tlevel),
    .m_axis_out_tempty (m_tempty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] u, input logic [1:0] k, input logic l);
    beat_t b;
    b.d = d; b.u = u; b.k = k; b.l = l;
    sb.push_back(b);
  endtask

  // Offer one sample and hold it until accepted; returns just after the accepting edge.
  task automatic send(input logic [15:0] d, input logic u, input logic l);
    int t;
    @(negedge clk);
    s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
    t = 0;
    #1;
    while (!s_tready && t < 300) begin
      @(negedge clk);
      #1;
      t++;
    end
    if (!s_tready) begin
      n_vec++;
      n_err++;
      $display("FAIL send_timeout: tready stayed %b, expected 1", s_tready);
    end
    @(negedge clk);
    s_tvalid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    #1;
    chk("drain_pending", 64'(sb.size()), 64'd0);
    chk("drain_tvalid", 64'(m_tvalid), 64'd0);
    chk("drain_tempty", 64'(m_tempty), 64'd1);
  endtask

  // Monitor: every output handshake is compared against the scoreboard head.
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      #1;
      if (m_tvalid && m_tready && !reset_i) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_beat: got data=%h keep=%b last=%b, expected no beat", m_tdata, m_tkeep, m_tlast);
        end else begin
          e = sb.pop_front();
          chk("beat_data", 64'(m_tdata), 64'(e.d));
          chk("beat_user_keep_last", 64'({m_tuser, m_tkeep, m_tlast}), 64'({e.u, e.k, e.l}));
        end
      end
    end
  end

  initial begin : rnd_ready
    forever begin
      @(negedge clk);
      if (rnd_mode) m_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] pd [8];
    logic        pu [8];
    int          total;
    int          len;

    reset_i = 1'b1; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0; s_tvalid = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid",   64'(m_tvalid), 64'd0);
    chk("rst_tdata",    64'(m_tdata),  64'd0);
    chk("rst_tkeep",    64'(m_tkeep),  64'd0);
    chk("rst_tlast",    64'(m_tlast),  64'd0);
    chk("rst_tlevel",   64'(m_tlevel), 64'd0);
    chk("rst_tempty",   64'(m_tempty), 64'd1);
    chk("rst_in_ready", 64'(s_tready), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(s_tready), 64'd1);

    // Two samples form one full beat; check the one-cycle load latency.
    m_tready = 1'b1;
    push(32'h0002_0001, 2'b00, 2'b11, 1'b0);
    send(16'h0001, 1'b0, 1'b0);
    send(16'h0002, 1'b0, 1'b0);
    #1;
    chk("latency_edge_n", 64'(m_tvalid), 64'd0);
    @(negedge clk);
    #1;
    chk("latency_edge_n1", 64'(m_tvalid), 64'd1);
    wait_drain();

    // Three-sample packet: full beat then a single-lane closing beat.
    push(32'h000B_000A, 2'b00, 2'b11, 1'b0);
    push(32'h0000_000C, 2'b00, 2'b01, 1'b1);
    send(16'h000A, 1'b0, 1'b0);
    send(16'h000B, 1'b0, 1'b0);
    send(16'h000C, 1'b0, 1'b1);
    wait_drain();

    // Backpressure: two samples in the output register plus eight stored.
    m_tready = 1'b0;
    for (int i = 1; i <= 10; i += 2) push({16'h0100 + 16'(i + 1), 16'h0100 + 16'(i)}, 2'b00, 2'b11, 1'b0);
    for (int i = 1; i <= 10; i++) send(16'h0100 + 16'(i), 1'b0, 1'b0);
    #1;
    chk("full_in_ready", 64'(s_tready), 64'd0);
    chk("full_tlevel",   64'(m_tlevel), 64'd8);
    @(negedge clk);
    m_tready = 1'b1;
    @(negedge clk);
    m_tready = 1'b0;
    #1;
    chk("unfull_in_ready", 64'(s_tready), 64'd1);
    chk("unfull_tlevel",   64'(m_tlevel), 64'd6);
    @(negedge clk);
    m_tready = 1'b1;
    wait_drain();

    // Reset in the middle of a packet discards everything.
    m_tready = 1'b0;
    for (int i = 1; i <= 5; i++) send(16'h0200 + 16'(i), 1'b0, 1'b0);
    reset_i = 1'b1;
    #1;
    chk("midrst_in_ready", 64'(s_tready), 64'd0);
    @(negedge clk);
    reset_i = 1'b0;
    #1;
    chk("midrst_tvalid", 64'(m_tvalid), 64'd0);
    chk("midrst_tlevel", 64'(m_tlevel), 64'd0);
    chk("midrst_tempty", 64'(m_tempty), 64'd1);
    m_tready = 1'b1;
    push(32'h0000_0001, 2'b00, 2'b01, 1'b1);
    send(16'h0001, 1'b0, 1'b1);
    wait_drain();

    // Random packets with random backpressure on both sides.
    rnd_mode = 1'b1;
    total = 0;
    while (total < 200) begin
      len = $urandom_range(1, 7);
      if (total + len > 200) len = 200 - total;
      for (int i = 0; i < len; i++) begin
        pd[i] = 16'($urandom);
        pu[i] = 1'($urandom_range(0, 1));
      end
      for (int i = 0; i < len; i += 2) begin
        if (i + 1 < len) push({pd[i+1], pd[i]}, {pu[i+1], pu[i]}, 2'b11, (i + 1 == len - 1));
        else             push({16'h0000, pd[i]}, {1'b0, pu[i]}, 2'b01, 1'b1);
      end
      for (int i = 0; i < len; i++) begin
        send(pd[i], pu[i], (i == len - 1));
        if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
      total += len;
    end
    rnd_mode = 1'b0;
    @(negedge clk);
    m_tready = 1'b1;
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
